// File: rtl/mem_arbiter_mc_if.sv
// Requester, response and RAM/IO bus signals of the byte-serial memory arbiter.
// The arbiter connects through the slave modport; requesters and memory drive the master side.
interface mem_arbiter_mc_if #(
  parameter int NCH    = 2,
  parameter int MAXLEN = 4,
  parameter int LEN_W  = $clog2(MAXLEN + 1)
);
  logic                      rdy_in;
  logic [NCH-1:0]            req_valid;
  logic [NCH-1:0]            req_we;
  logic [32*NCH-1:0]         req_addr;
  logic [LEN_W*NCH-1:0]      req_len;
  logic [8*MAXLEN*NCH-1:0]   req_wdata;
  logic [NCH-1:0]            flush_in;
  logic [NCH-1:0]            resp_done;
  logic [8*MAXLEN-1:0]       resp_data;
  logic                      busy;
  logic [7:0]                mem_din;
  logic [7:0]                mem_dout;
  logic [31:0]               mem_a;
  logic                      mem_wr;
  logic                      io_buffer_full;

  modport master (
    output rdy_in, req_valid, req_we, req_addr, req_len, req_wdata, flush_in,
           mem_din, io_buffer_full,
    input  resp_done, resp_data, busy, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  rdy_in, req_valid, req_we, req_addr, req_len, req_wdata, flush_in,
           mem_din, io_buffer_full,
    output resp_done, resp_data, busy, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter_mc.sv
// Round-robin arbiter and byte-serial burst controller for NCH requesters sharing
// one 8-bit RAM/IO bus, with read flush and UART back-pressure stalls on IO writes.
module mem_arbiter_mc #(
  parameter int NCH    = 2,
  parameter int MAXLEN = 4,
  parameter int LEN_W  = $clog2(MAXLEN + 1)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  mem_arbiter_mc_if.slave     bus
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DW   = 8 * MAXLEN;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_WR     = 3'd2,
    S_IOWAIT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d, ch_q, ch_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d, pidx_q, pidx_d;
  logic [DW-1:0]     wdata_q, wdata_d, rdata_q, rdata_d;
  logic              pend_q, pend_d;

  logic              gnt_valid_s;
  logic [CH_W-1:0]   gnt_ch_s, cand_s;
  logic [LEN_W-1:0]  len_raw_s, len_eff_s;
  logic [31:0]       cur_addr_s;
  logic              io_stall_s, flush_hit_s;

  // Search starts just after the last granted channel, so every waiter is served within NCH grants.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_ch_s    = '0;
    cand_s      = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand_s = CH_W'((int'(ptr_q) + i) % NCH);
      if (!gnt_valid_s && bus.req_valid[cand_s]) begin
        gnt_valid_s = 1'b1;
        gnt_ch_s    = cand_s;
      end else begin
        gnt_ch_s    = gnt_ch_s;
      end
    end
  end

  assign len_raw_s = bus.req_len[int'(gnt_ch_s)*LEN_W +: LEN_W];

  always_comb begin
    if (len_raw_s == '0) begin
      len_eff_s = LEN_W'(1);
    end else if (len_raw_s > LEN_W'(MAXLEN)) begin
      len_eff_s = LEN_W'(MAXLEN);
    end else begin
      len_eff_s = len_raw_s;
    end
  end

  assign cur_addr_s  = addr_q + 32'(cnt_q);
  assign io_stall_s  = (state_q == S_WR) && (cur_addr_s[17:16] == 2'b11) && bus.io_buffer_full;
  assign flush_hit_s = !we_q && bus.flush_in[ch_q] && ((state_q == S_RD) || (state_q == S_DONE));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      ptr_q   <= CH_W'(NCH - 1);
      ch_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      len_q   <= '0;
      cnt_q   <= '0;
      pidx_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      pidx_q  <= pidx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      pend_q  <= pend_d;
    end
  end

  // pend_q marks a read address issued last cycle; its byte lands even if rdy_in has since dropped.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ch_d    = ch_q;
    we_d    = we_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    pend_d  = 1'b0;
    pidx_d  = cnt_q;
    if (pend_q) begin
      rdata_d[int'(pidx_q)*8 +: 8] = bus.mem_din;
    end else begin
      rdata_d = rdata_q;
    end
    case (state_q)
      S_IDLE: begin
        if (bus.rdy_in && gnt_valid_s) begin
          ch_d    = gnt_ch_s;
          ptr_d   = gnt_ch_s;
          we_d    = bus.req_we[gnt_ch_s];
          addr_d  = bus.req_addr[int'(gnt_ch_s)*32 +: 32];
          len_d   = len_eff_s;
          wdata_d = bus.req_wdata[int'(gnt_ch_s)*DW +: DW];
          cnt_d   = '0;
          rdata_d = '0;
          state_d = bus.req_we[gnt_ch_s] ? S_WR : S_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (flush_hit_s) begin
          rdata_d = '0;
          state_d = S_IDLE;
        end else if (!bus.rdy_in) begin
          state_d = S_RD;
        end else if (cnt_q == len_q) begin
          state_d = S_DONE;
        end else begin
          pend_d  = 1'b1;
          cnt_d   = cnt_q + LEN_W'(1);
        end
      end
      S_WR: begin
        if (!bus.rdy_in) begin
          state_d = S_WR;
        end else if (io_stall_s) begin
          state_d = S_IOWAIT;
        end else if (cnt_q == len_q - LEN_W'(1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + LEN_W'(1);
        end
      end
      S_IOWAIT: begin
        if (bus.rdy_in && !bus.io_buffer_full) begin
          state_d = S_WR;
        end else begin
          state_d = S_IOWAIT;
        end
      end
      S_DONE: begin
        if (flush_hit_s) begin
          rdata_d = '0;
          state_d = S_IDLE;
        end else if (bus.rdy_in) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The done pulse is qualified by rdy_in so a paused DONE still reports exactly once.
  always_comb begin
    bus.resp_done = '0;
    bus.resp_data = '0;
    bus.busy      = (state_q != S_IDLE);
    bus.mem_a     = 32'h0;
    bus.mem_dout  = 8'h00;
    bus.mem_wr    = 1'b0;
    case (state_q)
      S_RD: begin
        if (cnt_q != len_q) begin
          bus.mem_a = cur_addr_s;
        end else begin
          bus.mem_a = 32'h0;
        end
      end
      S_WR: begin
        bus.mem_a    = cur_addr_s;
        bus.mem_dout = wdata_q[int'(cnt_q)*8 +: 8];
        bus.mem_wr   = bus.rdy_in && !io_stall_s;
      end
      S_DONE: begin
        bus.resp_data = rdata_q;
        if (bus.rdy_in && !flush_hit_s) begin
          bus.resp_done[ch_q] = 1'b1;
        end else begin
          bus.resp_done = '0;
        end
      end
      default: bus.mem_a = 32'h0;
    endcase
  end

endmodule
